// File: rtl/id_ctrl_unit.sv
// -----------------------------------------------------------------------------
// id_ctrl_unit
//
// Decode-stage controller for a five-stage RV32I pipeline.
//   * Decodes instr_d into the immediate-type select and the datapath control
//     word, and holds that word in the ID/EX control register (_e outputs).
//   * Detects load-use hazards against the instruction in EX and produces the
//     stall/flush controls for the IF/ID/EX pipeline registers.
//   * Applies the EX-stage redirect flush, which outranks a hazard stall.
//
// Ports
//   clk, rst_n      pipeline clock, asynchronous active-low reset
//   instr_d         instruction word in ID
//   valid_d         instr_d holds a real instruction
//   rd_e            destination register of the instruction in EX
//   redirect_e      branch taken / jump resolved in EX
//   imm_field_d     instr_d[31:7] for the immediate generator
//   imm_src_d       000 I, 001 S, 010 B, 011 U, 100 J
//   illegal_d       valid_d with an unsupported opcode
//   stall_f/d       hold PC / IF-ID register
//   flush_d/e       clear IF-ID / ID-EX register
//   *_e             registered control word (one-cycle latency)
//
// Configuration
//   ID_CTRL_PERF_EN  when defined, adds saturating 32-bit counters stall_cnt
//                    (load-use stall cycles) and flush_cnt (redirect cycles).
// -----------------------------------------------------------------------------
module id_ctrl_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_d,
    input  logic        valid_d,
    input  logic [4:0]  rd_e,
    input  logic        redirect_e,
    output logic [24:0] imm_field_d,
    output logic [2:0]  imm_src_d,
    output logic        illegal_d,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_d,
    output logic        flush_e,
    output logic        valid_e,
    output logic        reg_write_e,
    output logic        mem_write_e,
    output logic        alu_src_e,
    output logic        branch_e,
    output logic        jump_e,
    output logic [1:0]  result_src_e,
    output logic [1:0]  alu_op_e,
    output logic [2:0]  funct3_e,
    output logic        funct7b5_e
`ifdef ID_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [6:0] opcode_s;
    logic [4:0] rs1_s;
    logic [4:0] rs2_s;

    logic       known_s;
    logic [2:0] imm_src_s;
    logic       reg_write_s;
    logic       mem_write_s;
    logic       alu_src_s;
    logic       branch_s;
    logic       jump_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_op_s;
    logic       uses_rs1_s;
    logic       uses_rs2_s;

    logic       hazard_s;
    logic       stall_s;
    logic       flush_d_s;
    logic       flush_e_s;

    logic       valid_e_r;
    logic       reg_write_e_r;
    logic       mem_write_e_r;
    logic       alu_src_e_r;
    logic       branch_e_r;
    logic       jump_e_r;
    logic [1:0] result_src_e_r;
    logic [1:0] alu_op_e_r;
    logic [2:0] funct3_e_r;
    logic       funct7b5_e_r;

    assign opcode_s    = instr_d[6:0];
    assign rs1_s       = instr_d[19:15];
    assign rs2_s       = instr_d[24:20];
    assign imm_field_d = instr_d[31:7];

    // Opcode decode into immediate type, control word and source-register usage.
    always_comb begin
        known_s      = 1'b1;
        imm_src_s    = 3'b000;
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        alu_src_s    = 1'b0;
        branch_s     = 1'b0;
        jump_s       = 1'b0;
        result_src_s = 2'b00;
        alu_op_s     = 2'b00;
        uses_rs1_s   = 1'b1;
        uses_rs2_s   = 1'b0;
        case (opcode_s)
            OP_LOAD: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                alu_src_s    = 1'b1;
            end
            OP_IMM: begin
                alu_op_s    = 2'b10;
                reg_write_s = 1'b1;
                alu_src_s   = 1'b1;
            end
            OP_JALR: begin
                jump_s       = 1'b1;
                result_src_s = 2'b10;
                reg_write_s  = 1'b1;
            end
            OP_STORE: begin
                imm_src_s   = 3'b001;
                mem_write_s = 1'b1;
                alu_src_s   = 1'b1;
                uses_rs2_s  = 1'b1;
            end
            OP_BRANCH: begin
                imm_src_s  = 3'b010;
                branch_s   = 1'b1;
                alu_op_s   = 2'b01;
                uses_rs2_s = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm_src_s   = 3'b011;
                reg_write_s = 1'b1;
                alu_src_s   = 1'b1;
                uses_rs1_s  = 1'b0;
            end
            OP_JAL: begin
                imm_src_s    = 3'b100;
                jump_s       = 1'b1;
                result_src_s = 2'b10;
                reg_write_s  = 1'b1;
                uses_rs1_s   = 1'b0;
            end
            OP_REG: begin
                alu_op_s    = 2'b10;
                reg_write_s = 1'b1;
                uses_rs2_s  = 1'b1;
            end
            default: begin
                known_s = 1'b0;
            end
        endcase
    end

    assign imm_src_d = imm_src_s;
    assign illegal_d = valid_d & ~known_s;

    // A load in EX whose destination feeds this instruction needs one bubble.
    // The bubble leaves valid_e low next cycle, so the stall self-terminates.
    assign hazard_s = valid_e_r
                    & (result_src_e_r == 2'b01)
                    & (rd_e != 5'd0)
                    & valid_d
                    & ((uses_rs1_s & (rd_e == rs1_s)) | (uses_rs2_s & (rd_e == rs2_s)));

    // Stall/flush arbitration: a redirect discards ID, so it overrides a stall.
    always_comb begin
        stall_s   = 1'b0;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        if (redirect_e) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (hazard_s) begin
            stall_s   = 1'b1;
            flush_e_s = 1'b1;
        end else begin
            stall_s   = 1'b0;
        end
    end

    assign stall_f = stall_s;
    assign stall_d = stall_s;
    assign flush_d = flush_d_s;
    assign flush_e = flush_e_s;

    // ID/EX control register: bubble on flush or empty ID slot, else decoded word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_e_r      <= 1'b0;
            reg_write_e_r  <= 1'b0;
            mem_write_e_r  <= 1'b0;
            alu_src_e_r    <= 1'b0;
            branch_e_r     <= 1'b0;
            jump_e_r       <= 1'b0;
            result_src_e_r <= 2'b00;
            alu_op_e_r     <= 2'b00;
            funct3_e_r     <= 3'b000;
            funct7b5_e_r   <= 1'b0;
        end else if (flush_e_s || !valid_d) begin
            valid_e_r      <= 1'b0;
            reg_write_e_r  <= 1'b0;
            mem_write_e_r  <= 1'b0;
            alu_src_e_r    <= 1'b0;
            branch_e_r     <= 1'b0;
            jump_e_r       <= 1'b0;
            result_src_e_r <= 2'b00;
            alu_op_e_r     <= 2'b00;
            funct3_e_r     <= 3'b000;
            funct7b5_e_r   <= 1'b0;
        end else begin
            valid_e_r      <= 1'b1;
            reg_write_e_r  <= reg_write_s;
            mem_write_e_r  <= mem_write_s;
            alu_src_e_r    <= alu_src_s;
            branch_e_r     <= branch_s;
            jump_e_r       <= jump_s;
            result_src_e_r <= result_src_s;
            alu_op_e_r     <= alu_op_s;
            funct3_e_r     <= instr_d[14:12];
            funct7b5_e_r   <= instr_d[30];
        end
    end

    assign valid_e      = valid_e_r;
    assign reg_write_e  = reg_write_e_r;
    assign mem_write_e  = mem_write_e_r;
    assign alu_src_e    = alu_src_e_r;
    assign branch_e     = branch_e_r;
    assign jump_e       = jump_e_r;
    assign result_src_e = result_src_e_r;
    assign alu_op_e     = alu_op_e_r;
    assign funct3_e     = funct3_e_r;
    assign funct7b5_e   = funct7b5_e_r;

`ifdef ID_CTRL_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Saturating event counters for load-use stall cycles and redirect cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'h0000_0000;
            flush_cnt_r <= 32'h0000_0000;
        end else begin
            if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (redirect_e && (flush_cnt_r != 32'hFFFF_FFFF)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule
